// File: rtl/vram_painter.sv
// Pixel write engine for the scan-out canvas VRAM: rasterises point, filled
// rectangle and clear commands into one 12-bit pixel write per pclk.
module vram_painter #(
    parameter int DW    = 15,
    parameter int H_LEN = 200,
    parameter int V_LEN = 150,
    parameter int CW    = 8
) (
    input  logic          pclk,
    input  logic          rstn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [CW-1:0] cmd_x0,
    input  logic [CW-1:0] cmd_y0,
    input  logic [CW-1:0] cmd_x1,
    input  logic [CW-1:0] cmd_y1,
    input  logic [11:0]   cmd_color,
    output logic          we,
    output logic [DW-1:0] waddr,
    output logic [11:0]   wdata,
    output logic          busy,
    output logic          done
);

    localparam logic [CW-1:0] X_MAX = CW'(H_LEN - 1);
    localparam logic [CW-1:0] Y_MAX = CW'(V_LEN - 1);

    typedef enum logic [1:0] {IDLE, DRAW, EMPTY} state_t;

    state_t        state;
    logic [CW-1:0] bx0, bx1, by1, cx, cy;

    logic [CW-1:0] lo_x, lo_y, hi_x, hi_y;
    logic          cmd_empty, first_last;
    logic [DW-1:0] start_addr;
    logic [CW-1:0] nx, ny;
    logic          next_last;

    assign cmd_ready = (state == IDLE);

    // Resolve the command into clipped inclusive bounds before it is latched.
    always_comb begin
        lo_x = cmd_x0;
        lo_y = cmd_y0;
        hi_x = cmd_x1;
        hi_y = cmd_y1;
        case (cmd_op)
            2'b00: begin
                hi_x = cmd_x0;
                hi_y = cmd_y0;
            end
            2'b10: begin
                lo_x = '0;
                lo_y = '0;
                hi_x = X_MAX;
                hi_y = Y_MAX;
            end
            default: ;
        endcase
        if (hi_x > X_MAX) hi_x = X_MAX;
        if (hi_y > Y_MAX) hi_y = Y_MAX;
        cmd_empty  = (cmd_op == 2'b11) || (lo_x > X_MAX) || (lo_y > Y_MAX)
                     || (lo_x > hi_x) || (lo_y > hi_y);
        first_last = (lo_x == hi_x) && (lo_y == hi_y);
        start_addr = DW'(lo_y) * DW'(H_LEN) + DW'(lo_x);
    end

    always_comb begin
        nx = cx + CW'(1);
        ny = cy;
        if (cx == bx1) begin
            nx = bx0;
            ny = cy + CW'(1);
        end
        next_last = (nx == bx1) && (ny == by1);
    end

    // done doubles as the "pixel on the bus is the last one" flag while drawing.
    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            bx0   <= '0;
            bx1   <= '0;
            by1   <= '0;
            cx    <= '0;
            cy    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    we   <= 1'b0;
                    done <= 1'b0;
                    if (cmd_valid) begin
                        busy <= 1'b1;
                        if (cmd_empty) begin
                            state <= EMPTY;
                            done  <= 1'b1;
                        end else begin
                            state <= DRAW;
                            we    <= 1'b1;
                            waddr <= start_addr;
                            wdata <= cmd_color;
                            done  <= first_last;
                            bx0   <= lo_x;
                            bx1   <= hi_x;
                            by1   <= hi_y;
                            cx    <= lo_x;
                            cy    <= lo_y;
                        end
                    end
                end
                DRAW: begin
                    if (done) begin
                        state <= IDLE;
                        we    <= 1'b0;
                        done  <= 1'b0;
                        busy  <= 1'b0;
                    end else begin
                        we   <= 1'b1;
                        done <= next_last;
                        cx   <= nx;
                        cy   <= ny;
                        // Row wrap jumps from (x1,y) to (x0,y+1) without a multiply.
                        if (cx == bx1)
                            waddr <= waddr + DW'(H_LEN) - DW'(bx1) + DW'(bx0);
                        else
                            waddr <= waddr + DW'(1);
                    end
                end
                EMPTY: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    we    <= 1'b0;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_painter.sv
// Scoreboard bench for vram_painter: a pixel-list model queues every expected
// write (tagged with its cycle) and a monitor checks the DUT against it.
module tb_vram_painter;

    localparam int DW    = 15;
    localparam int H_LEN = 200;
    localparam int V_LEN = 150;
    localparam int CW    = 8;

    logic          pclk = 1'b0;
    logic          rstn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = '0;
    logic [CW-1:0] cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
    logic [11:0]   cmd_color = '0;
    logic          we, busy, done;
    logic [DW-1:0] waddr;
    logic [11:0]   wdata;

    typedef struct {
        int unsigned cyc;
        bit          we;
        int          addr;
        int          data;
        bit          done;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned cyc = 0;
    int unsigned last_evt = 0;
    int          tests = 0;
    int          fails = 0;
    bit          prev_done = 1'b0;

    vram_painter #(.DW(DW), .H_LEN(H_LEN), .V_LEN(V_LEN), .CW(CW)) dut (
        .pclk(pclk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1),
        .cmd_y1(cmd_y1), .cmd_color(cmd_color), .we(we), .waddr(waddr),
        .wdata(wdata), .busy(busy), .done(done)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            if (fails <= 30)
                $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    // Reference model: the pixel set a command covers, listed in raster order.
    task automatic pushExpected(input int op, input int x0, input int y0, input int x1,
                                input int y1, input int color, input int unsigned acc);
        int lx = x0, ly = y0, hx = x1, hy = y1;
        int unsigned k = 0;
        if (op == 0) begin
            hx = x0;
            hy = y0;
        end else if (op == 2) begin
            lx = 0;
            ly = 0;
            hx = H_LEN - 1;
            hy = V_LEN - 1;
        end
        if (hx > H_LEN - 1) hx = H_LEN - 1;
        if (hy > V_LEN - 1) hy = V_LEN - 1;
        if (op == 3 || lx >= H_LEN || ly >= V_LEN || lx > hx || ly > hy) begin
            sb.push_back('{cyc: acc + 1, we: 1'b0, addr: 0, data: 0, done: 1'b1});
            last_evt = acc + 1;
        end else begin
            for (int y = ly; y <= hy; y++)
                for (int x = lx; x <= hx; x++) begin
                    k++;
                    sb.push_back('{cyc: acc + k, we: 1'b1, addr: y * H_LEN + x,
                                   data: color, done: (x == hx && y == hy)});
                end
            last_evt = acc + k;
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic applyStimulus(input int op, input int x0, input int y0, input int x1,
                                 input int y1, input int color, input bit keep,
                                 output int unsigned acc);
        bit got = 1'b0;
        acc       = 0;
        cmd_op    = 2'(op);
        cmd_x0    = 8'(x0);
        cmd_y0    = 8'(y0);
        cmd_x1    = 8'(x1);
        cmd_y1    = 8'(y1);
        cmd_color = 12'(color);
        cmd_valid = 1'b1;
        for (int i = 0; i < 40000 && !got; i++) begin
            if (cmd_ready) begin
                got = 1'b1;
                acc = cyc;
                pushExpected(op, x0, y0, x1, y1, color, cyc);
            end
            @(negedge pclk);
        end
        if (!keep || !got) cmd_valid = 1'b0;
        if (!got) checkOutput("accept_timeout", 0, 1);
    endtask

    // Monitor: pop the entry scheduled for this cycle, otherwise the bus must be quiet.
    always @(negedge pclk) begin
        if (rstn) begin
            if (prev_done) begin
                checkOutput("busy_after_done", int'(busy), 0);
                checkOutput("ready_after_done", int'(cmd_ready), 1);
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                mon_e = sb.pop_front();
                checkOutput("we", int'(we), int'(mon_e.we));
                checkOutput("done", int'(done), int'(mon_e.done));
                checkOutput("busy", int'(busy), 1);
                if (mon_e.we) begin
                    checkOutput("waddr", int'(waddr), mon_e.addr);
                    checkOutput("wdata", int'(wdata), mon_e.data);
                end
            end else if (we || done) begin
                checkOutput("unexpected_we_done", int'({we, done}), 0);
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    initial begin
        int unsigned acc, acc2, last1;
        int op, x0, y0, x1, y1;
        bit keep;

        #3;
        checkOutput("reset_we", int'(we), 0);
        checkOutput("reset_waddr", int'(waddr), 0);
        checkOutput("reset_wdata", int'(wdata), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_ready", int'(cmd_ready), 1);
        repeat (2) @(negedge pclk);
        #2 rstn = 1'b1;
        @(negedge pclk);

        applyStimulus(0, 3, 2, 0, 0, 12'hF00, 1'b0, acc);
        applyStimulus(1, 198, 148, 205, 160, 12'h0F0, 1'b0, acc);
        applyStimulus(2, 0, 0, 0, 0, 12'h00F, 1'b0, acc);
        applyStimulus(1, 210, 5, 220, 9, 12'h123, 1'b0, acc);
        applyStimulus(1, 5, 5, 4, 9, 12'h456, 1'b0, acc);
        applyStimulus(3, 1, 1, 5, 5, 12'h789, 1'b0, acc);

        applyStimulus(1, 20, 30, 25, 33, 12'hABC, 1'b1, acc);
        last1 = last_evt;
        applyStimulus(1, 100, 60, 102, 61, 12'h5A5, 1'b0, acc2);
        checkOutput("hold_accept_cycle", int'(acc2), int'(last1 + 1));

        for (int n = 0; n < 30; n++) begin
            op = int'($urandom_range(0, 3));
            if (op == 2) op = 1;
            x0 = int'($urandom_range(0, 210));
            y0 = int'($urandom_range(0, 160));
            x1 = x0 + int'($urandom_range(0, 12)) - 2;
            y1 = y0 + int'($urandom_range(0, 8)) - 2;
            if (x1 < 0) x1 = 0;
            if (x1 > 255) x1 = 255;
            if (y1 < 0) y1 = 0;
            if (y1 > 255) y1 = 255;
            keep = ($urandom_range(0, 3) == 0) && (n != 29);
            applyStimulus(op, x0, y0, x1, y1, int'($urandom_range(0, 4095)), keep, acc);
        end

        for (int i = 0; i < 40000 && sb.size() > 0; i++) @(negedge pclk);
        applyStimulus(1, 10, 20, 19, 29, 12'hC3C, 1'b0, acc);
        for (int i = 0; i < 200 && cyc != acc + 37; i++) @(negedge pclk);
        checkOutput("reach_write_37", int'(cyc), int'(acc + 37));
        #2 rstn = 1'b0;
        #1;
        checkOutput("midreset_we", int'(we), 0);
        checkOutput("midreset_done", int'(done), 0);
        checkOutput("midreset_busy", int'(busy), 0);
        checkOutput("midreset_waddr", int'(waddr), 0);
        sb.delete();
        repeat (3) @(negedge pclk);
        #2 rstn = 1'b1;
        @(negedge pclk);
        checkOutput("ready_after_reset", int'(cmd_ready), 1);
        applyStimulus(0, 7, 9, 0, 0, 12'h3E7, 1'b0, acc);

        for (int i = 0; i < 40000 && sb.size() > 0; i++) @(negedge pclk);
        if (sb.size() > 0) checkOutput("drain_timeout", sb.size(), 0);
        repeat (3) @(negedge pclk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
